// File: rtl/csa_resolver_pkg.sv
// Shared types and elaboration helpers for the chunked carry-save resolver.
// Pure compile-time content: no logic is generated from this package.
package csa_resolver_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int nchunk(input int width, input int chunk);
      return width / chunk;
   endfunction

   // A legal configuration splits the word into whole, non-empty chunks.
   function automatic bit cfg_ok(input int width, input int chunk);
      return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/csa_resolver_ripple_adder.sv
// Combinational CHUNK-bit ripple-carry adder made from a chain of full_adder cells.
module ripple_adder #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   logic [CHUNK:0] carry;

   assign carry[0] = cin;

   for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
      full_adder u_fa (
         .a    (a[gi]),
         .b    (b[gi]),
         .cin  (carry[gi]),
         .sum  (sum[gi]),
         .cout (carry[gi+1])
      );
   end

   assign cout = carry[CHUNK];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell; the building block of the per-chunk ripple chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/csa_resolver.sv
// Resolves a redundant (sum, carry) pair to binary by adding CHUNK bits per cycle,
// with the inter-chunk carry held in a register between cycles.
module csa_resolver
   import csa_resolver_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] sum_i,
   input  logic [WIDTH-1:0] carry_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             cout_o
);

   localparam int NCHUNK = nchunk(WIDTH, CHUNK);
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
      $error("csa_resolver: WIDTH must be a non-zero multiple of CHUNK");
   end

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic [WIDTH-1:0]  carry_q, carry_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic              cout_q, cout_d;
   logic [KW-1:0]     idx_q, idx_d;
   logic              c_q, c_d;

   logic [CHUNK-1:0]  sum_ch   [NCHUNK];
   logic [CHUNK-1:0]  carry_ch [NCHUNK];
   logic [CHUNK-1:0]  add_sum;
   logic              add_cout;

   for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
      assign sum_ch[gi]   = sum_q[gi*CHUNK +: CHUNK];
      assign carry_ch[gi] = carry_q[gi*CHUNK +: CHUNK];
   end

   ripple_adder #(.CHUNK(CHUNK)) u_adder (
      .a    (sum_ch[idx_q]),
      .b    (carry_ch[idx_q]),
      .cin  (c_q),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_comb begin
      state_d  = state_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      result_d = result_q;
      cout_d   = cout_q;
      idx_d    = idx_q;
      c_d      = c_q;
      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               sum_d   = sum_i;
               carry_d = carry_i;
               idx_d   = '0;
               c_d     = 1'b0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            for (int i = 0; i < NCHUNK; i++) begin
               if (idx_q == KW'(i)) begin
                  result_d[i*CHUNK +: CHUNK] = add_sum;
               end
            end
            c_d = add_cout;
            if (idx_q == KW'(NCHUNK - 1)) begin
               cout_d  = add_cout;
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            // Result registers are deliberately left untouched on handoff.
            if (out_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         sum_q    <= '0;
         carry_q  <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         idx_q    <= '0;
         c_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         idx_q    <= idx_d;
         c_q      <= c_d;
      end
   end

   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);
   assign result_o    = result_q;
   assign cout_o      = cout_q;

endmodule
